hilo_muldiv_unit: RTL and testbench
===================================

// Module: hilo_muldiv_unit
// PURPOSE
//  EX-stage producer for the HI/LO special registers: MULT/MULTU/DIV/DIVU (multi-cycle) and MTHI/MTLO (single-cycle).
//  Drives the HI/LO write port of the register file and the 66-bit HI/LO forwarding bus that the register file reads.
//  Holds the pipeline with stall_req while an iterative operation runs; discards work on flush.
// PARAMETERS
//  WIDTH   32   operand width; HI and LO are WIDTH bits each; bus width is 2*WIDTH+2
//  CNT_W   6    iteration counter width; must hold the value WIDTH
// PORTS
//  clk             in   1      rising-edge clock
//  rst             in   1      asynchronous reset, active-high
//  start           in   1      issue strobe; op/src1/src2 are sampled when start=1 in IDLE
//  op              in   3      0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 no-op
//  src1            in   WIDTH  rs value (multiplicand / dividend / MTHI-MTLO data)
//  src2            in   WIDTH  rt value (multiplier / divisor)
//  flush           in   1      abort current operation, no write
//  stall_req       out  1      hold IF/ID/EX while set
//  w_hi_we         out  1      HI write enable to register file
//  w_lo_we         out  1      LO write enable to register file
//  hi_i            out  WIDTH  HI write data
//  lo_i            out  WIDTH  LO write data
//  hilo_to_id_bus  out  2W+2   {w_hi_we, w_lo_we, hi_i, lo_i}; identical values to the four outputs above
// BEHAVIOUR
//  - Reset: state=IDLE, count=0, all operand/acc regs 0; stall_req=0, w_hi_we=0, w_lo_we=0, hi_i=0, lo_i=0.
//  - States: IDLE, RUN, FIX, DONE.
//  - IDLE: start & op MTHI -> same cycle, combinational: w_hi_we=1, hi_i=src1; w_lo_we=0; no stall. MTLO likewise on LO.
//  - IDLE: start & op 0-3 & !flush -> latch |src1|,|src2| (signed ops) or raw values (unsigned ops), latch result signs,
//    count<=0, go to RUN; stall_req=1 combinationally in this cycle (cycle T).
//  - RUN: one radix-2 step per cycle. MUL: shift-add into a 2W accumulator. DIV: restoring subtract into {rem, quo}.
//    count increments; after step count==WIDTH-1 -> FIX. RUN occupies T+1..T+WIDTH.
//  - FIX (T+WIDTH+1): sign correction. MULT: negate the 2W product if operand signs differ.
//    DIV: quotient negated if signs differ; remainder takes the dividend's sign. Unsigned ops pass through.
//  - DONE (T+WIDTH+2): w_hi_we=w_lo_we=1 for exactly this cycle; hi_i=product[2W-1:W] / remainder, lo_i=product[W-1:0] / quotient;
//    stall_req=0; next state IDLE.
//  - stall_req = (IDLE & start & op<=3) | RUN | FIX. DONE releases the stall so the dependent instruction reads the forwarded HI/LO.
//  - Divide by zero (src2==0): no trap; full iteration still runs; result is defined as lo_i=all ones, hi_i=src1 (unsigned)
//    or sign-corrected equivalent per the rules above applied to quo=all ones, rem=|src1|.
//  - Signed overflow: DIV of most-negative by -1 yields lo_i=most-negative, hi_i=0 (wraps, no flag).
//  - start while not IDLE: ignored. start with op 6-7: ignored, no stall.
//  - flush: in any state -> IDLE next cycle, no write enables that cycle or after; flush in IDLE with start: no latch, no stall.
//  - Reset mid-operation: immediate return to reset values; no partial write ever appears.
//  - Outside DONE and MTHI/MTLO cycles: w_hi_we=w_lo_we=0; hi_i/lo_i hold last driven result (don't-care to consumers).
// CONFIGURATION
//  HILO_FAST_MUL_EN defined: MULT/MULTU computed by one combinational WxW multiplier; sign handled inside
//    the multiplier; IDLE->DONE directly, result written at T+1, stall_req high only in cycle T. DIV/DIVU unchanged.
//  HILO_FAST_MUL_EN undefined: multiplies use the iterative RUN/FIX path, result at T+WIDTH+2 (T+34 for WIDTH=32).
// TESTING
//  1. MULT src1=-3 (FFFFFFFD), src2=5 at T -> DONE T+34: hi_i=FFFFFFFF, lo_i=FFFFFFF1, both we=1 one cycle; stall_req 1 over T..T+33.
//  2. DIVU src1=100, src2=7 -> T+34: lo_i=0000000E, hi_i=00000002. DIV 7/-2 -> lo_i=FFFFFFFD, hi_i=00000001.
//  3. DIV src1=-7, src2=2 -> lo_i=FFFFFFFD, hi_i=FFFFFFFF; DIVU src1=5, src2=0 -> lo_i=FFFFFFFF, hi_i=00000005.
//  4. MTHI src1=12345678 -> same cycle w_hi_we=1, hi_i=12345678, w_lo_we=0, stall_req=0; bus[65:64]=2'b10.
//  5. MULTU start, flush at T+10 -> IDLE at T+11, no we pulse through T+40; new start at T+12 completes normally.
//  6. rst pulsed mid-DIV (asynchronous, between edges) -> all outputs 0 immediately; HILO_FAST_MUL_EN build: MULTU FFFFFFFF*2 -> T+1 hi=1, lo=FFFFFFFE.

Source files
------------

// File: rtl/hilo_muldiv_unit.sv
// HI/LO producer: iterative MULT/MULTU/DIV/DIVU plus single-cycle MTHI/MTLO.
// Define HILO_FAST_MUL_EN to compute multiplies with one combinational multiplier.
module hilo_muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [2:0]           op,
    input  logic [WIDTH-1:0]     src1,
    input  logic [WIDTH-1:0]     src2,
    input  logic                 flush,
    output logic                 stall_req,
    output logic                 w_hi_we,
    output logic                 w_lo_we,
    output logic [WIDTH-1:0]     hi_i,
    output logic [WIDTH-1:0]     lo_i,
    output logic [2*WIDTH+1:0]   hilo_to_id_bus
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

    state_t             r_state;
    state_t             w_state_nx;
    logic [CNT_W-1:0]   r_count;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_opnd;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_is_div;
    logic               r_neg_q;
    logic               r_neg_r;

    logic               w_idle;
    logic               w_issue;
    logic               w_mthi;
    logic               w_mtlo;
    logic               w_fast;
    logic               w_s1_neg;
    logic               w_s2_neg;
    logic [WIDTH-1:0]   w_abs1;
    logic [WIDTH-1:0]   w_abs2;
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_mul_nx;
    logic [WIDTH:0]     w_div_rem;
    logic [WIDTH:0]     w_div_dif;
    logic [2*WIDTH-1:0] w_div_nx;
    logic [2*WIDTH-1:0] w_fix_prod;
    logic [WIDTH-1:0]   w_fix_quo;
    logic [WIDTH-1:0]   w_fix_rem;

    assign w_idle   = (r_state == S_IDLE);
    assign w_issue  = w_idle & start & ~flush & ~op[2];
    assign w_mthi   = w_idle & start & ~flush & (op == 3'd4);
    assign w_mtlo   = w_idle & start & ~flush & (op == 3'd5);
    // Even opcodes (MULT, DIV) are the signed flavours
    assign w_s1_neg = ~op[0] & src1[WIDTH-1];
    assign w_s2_neg = ~op[0] & src2[WIDTH-1];
    assign w_abs1   = w_s1_neg ? -src1 : src1;
    assign w_abs2   = w_s2_neg ? -src2 : src2;

`ifdef HILO_FAST_MUL_EN
    logic [2*WIDTH-1:0] w_fast_prod;
    assign w_fast      = w_issue & ~op[1];
    assign w_fast_prod = {{WIDTH{w_s1_neg}}, src1} * {{WIDTH{w_s2_neg}}, src2};
`else
    assign w_fast = 1'b0;
`endif

    // Shift-add: multiplier sits in the low half and drains out the bottom
    assign w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                     + (r_acc[0] ? {1'b0, r_opnd} : '0);
    assign w_mul_nx  = {w_mul_sum, r_acc[WIDTH-1:1]};

    // Restoring divide on {rem, quo}; borrow bit decides the quotient bit
    assign w_div_rem = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    assign w_div_dif = w_div_rem - {1'b0, r_opnd};
    assign w_div_nx  = w_div_dif[WIDTH]
                     ? {w_div_rem[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                     : {w_div_dif[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};

    assign w_fix_prod = r_neg_q ? -r_acc : r_acc;
    assign w_fix_quo  = r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    assign w_fix_rem  = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH]
                                : r_acc[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE: if (w_issue) w_state_nx = w_fast ? S_DONE : S_RUN;
            S_RUN:  if (r_count == CNT_W'(WIDTH-1)) w_state_nx = S_FIX;
            S_FIX:  w_state_nx = S_DONE;
            S_DONE: w_state_nx = S_IDLE;
            default: w_state_nx = S_IDLE;
        endcase
        if (flush) w_state_nx = S_IDLE;
    end

    always_comb begin
        stall_req = w_issue | (r_state == S_RUN) | (r_state == S_FIX);
        w_hi_we   = w_mthi | ((r_state == S_DONE) & ~flush);
        w_lo_we   = w_mtlo | ((r_state == S_DONE) & ~flush);
        hi_i      = w_mthi ? src1 : r_hi;
        lo_i      = w_mtlo ? src1 : r_lo;
    end

    assign hilo_to_id_bus = {w_hi_we, w_lo_we, hi_i, lo_i};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count  <= '0;
            r_acc    <= '0;
            r_opnd   <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
        end else begin
            if (w_issue) begin
                r_count  <= '0;
                r_is_div <= op[1];
                r_neg_q  <= w_s1_neg ^ w_s2_neg;
                r_neg_r  <= w_s1_neg & op[1];
                if (op[1]) begin
                    r_acc  <= {{WIDTH{1'b0}}, w_abs1};
                    r_opnd <= w_abs2;
                end else begin
                    r_acc  <= {{WIDTH{1'b0}}, w_abs2};
                    r_opnd <= w_abs1;
                end
`ifdef HILO_FAST_MUL_EN
                if (w_fast) {r_hi, r_lo} <= w_fast_prod;
`endif
            end
            if (w_mthi) r_hi <= src1;
            if (w_mtlo) r_lo <= src1;
            if (r_state == S_RUN) begin
                r_acc   <= r_is_div ? w_div_nx : w_mul_nx;
                r_count <= r_count + 1'b1;
            end
            if (r_state == S_FIX) begin
                r_hi <= r_is_div ? w_fix_rem : w_fix_prod[2*WIDTH-1:WIDTH];
                r_lo <= r_is_div ? w_fix_quo : w_fix_prod[WIDTH-1:0];
            end
        end
    end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Scoreboard bench for hilo_muldiv_unit: directed corner cases plus random ops.
module tb_hilo_muldiv_unit;

    localparam int W = 32;
`ifdef HILO_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 34;
`endif
    localparam int DIV_LAT = 34;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [2:0]     op;
    logic [W-1:0]   src1;
    logic [W-1:0]   src2;
    logic           flush;
    logic           stall_req;
    logic           w_hi_we;
    logic           w_lo_we;
    logic [W-1:0]   hi_i;
    logic [W-1:0]   lo_i;
    logic [2*W+1:0] bus;

    hilo_muldiv_unit #(.WIDTH(W), .CNT_W(6)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op),
        .src1(src1), .src2(src2), .flush(flush),
        .stall_req(stall_req), .w_hi_we(w_hi_we), .w_lo_we(w_lo_we),
        .hi_i(hi_i), .lo_i(lo_i), .hilo_to_id_bus(bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int           due;
        logic         hwe;
        logic         lwe;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
    } exp_t;

    exp_t scb[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [2*W+1:0] got,
                       input logic [2*W+1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Architectural result of each op, straight from the arithmetic definition
    function automatic void model(input logic [2:0] o, input logic [W-1:0] a,
                                  input logic [W-1:0] b,
                                  output logic [W-1:0] hi,
                                  output logic [W-1:0] lo);
        longint          sa, sbv, qs, rs;
        longint unsigned ua, ub;
        logic [63:0]     p;
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        ua  = longint'(a);
        ub  = longint'(b);
        hi  = '0;
        lo  = '0;
        p   = '0;
        case (o)
            3'd0: begin p = sa * sbv; hi = p[63:32]; lo = p[31:0]; end
            3'd1: begin p = ua * ub;  hi = p[63:32]; lo = p[31:0]; end
            3'd2: begin
                if (b == 0) begin
                    lo = a[W-1] ? 32'd1 : 32'hFFFF_FFFF;
                    hi = a;
                end else begin
                    qs = sa / sbv;
                    rs = sa % sbv;
                    p  = qs;
                    lo = p[31:0];
                    p  = rs;
                    hi = p[31:0];
                end
            end
            3'd3: begin
                if (b == 0) begin
                    lo = 32'hFFFF_FFFF;
                    hi = a;
                end else begin
                    lo = a / b;
                    hi = a % b;
                end
            end
            3'd4: hi = a;
            3'd5: lo = a;
            default: ;
        endcase
    endfunction

    task automatic issue(input logic [2:0] o, input logic [W-1:0] a,
                         input logic [W-1:0] b);
        exp_t e;
        int   lat;
        lat = (o <= 3'd1) ? MUL_LAT : (o <= 3'd3) ? DIV_LAT : 0;
        start = 1'b1;
        op    = o;
        src1  = a;
        src2  = b;
        if (o <= 3'd5) begin
            model(o, a, b, e.hi, e.lo);
            e.due = cyc + lat;
            e.hwe = (o != 3'd5);
            e.lwe = (o != 3'd4);
            scb.push_back(e);
        end
        #1;
        chk("stall_issue", stall_req, (o <= 3'd3));
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 1; i <= lat; i++) begin
            chk("stall_busy", stall_req, (i < lat));
            start = (i == 3) && (i < lat);
            op    = 3'($urandom_range(0, 7));
            src1  = $urandom;
            src2  = $urandom;
            @(posedge clk);
            #1;
        end
        start = 1'b0;
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (w_hi_we | w_lo_we) begin
                    if (scb.size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL spurious_we: got we=%b%b at cycle %0d expected none",
                                 w_hi_we, w_lo_we, cyc);
                    end else begin
                        e = scb.pop_front();
                        chk("we", {w_hi_we, w_lo_we}, {e.hwe, e.lwe});
                        chk("latency", cyc, e.due);
                        chk("bus_we", bus[2*W+1:2*W], {e.hwe, e.lwe});
                        if (e.hwe) begin
                            chk("hi", hi_i, e.hi);
                            chk("bus_hi", bus[2*W-1:W], e.hi);
                        end
                        if (e.lwe) begin
                            chk("lo", lo_i, e.lo);
                            chk("bus_lo", bus[W-1:0], e.lo);
                        end
                    end
                end else if (scb.size() > 0 && scb[0].due < cyc) begin
                    e = scb.pop_front();
                    n_chk++;
                    n_fail++;
                    $display("FAIL timeout: no write by cycle %0d expected at %0d",
                             cyc, e.due);
                end
            end
        end
    end

    initial begin : driver
        rst   = 1'b1;
        start = 1'b0;
        flush = 1'b0;
        op    = '0;
        src1  = '0;
        src2  = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out", {w_hi_we, w_lo_we, hi_i, lo_i}, '0);
        chk("rst_stall", stall_req, '0);
        chk("rst_bus", bus, '0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        issue(3'd0, 32'hFFFF_FFFD, 32'd5);
        issue(3'd3, 32'd100, 32'd7);
        issue(3'd2, 32'd7, 32'hFFFF_FFFE);
        issue(3'd2, 32'hFFFF_FFF9, 32'd2);
        issue(3'd3, 32'd5, 32'd0);
        issue(3'd4, 32'h1234_5678, 32'd0);
        issue(3'd5, 32'hCAFE_F00D, 32'd0);
        issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        issue(3'd2, 32'h8000_0005, 32'd0);
        issue(3'd1, 32'hFFFF_FFFF, 32'd2);
        issue(3'd0, 32'h8000_0000, 32'h8000_0000);
        issue(3'd6, 32'd1, 32'd1);
        issue(3'd7, 32'd1, 32'd1);

        // MTHI with flush in the same cycle must not write
        start = 1'b1;
        op    = 3'd4;
        src1  = 32'hDEAD_BEEF;
        flush = 1'b1;
        #1;
        chk("mthi_flush_we", {w_hi_we, w_lo_we}, 2'b00);
        chk("mthi_flush_stall", stall_req, 1'b0);
        @(posedge clk);
        #1;
        start = 1'b0;
        flush = 1'b0;

        // Abort a long operation mid-flight
`ifdef HILO_FAST_MUL_EN
        op = 3'd3;
`else
        op = 3'd1;
`endif
        start = 1'b1;
        src1  = 32'hFFFF_0000;
        src2  = 32'h0000_1234;
        #1;
        chk("flush_issue_stall", stall_req, 1'b1);
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("flush_idle_stall", stall_req, 1'b0);
        @(posedge clk);
        #1;
        issue(3'd1, 32'h0001_0001, 32'h0000_FFFF);

        // Asynchronous reset between edges during a divide
        start = 1'b1;
        op    = 3'd2;
        src1  = 32'h7654_3210;
        src2  = 32'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_stall", stall_req, 1'b0);
        chk("midrst_out", {w_hi_we, w_lo_we, hi_i, lo_i}, '0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        issue(3'd3, 32'hFFFF_FFFF, 32'd16);

        for (int n = 0; n < 40; n++) begin
            logic [2:0]   ro;
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            ro = 3'($urandom_range(0, 7));
            ra = pick();
            rb = pick();
            issue(ro, ra, rb);
        end

        for (int i = 0; i < 100 && scb.size() > 0; i++) @(posedge clk);
        if (scb.size() > 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain: got %0d pending results expected 0", scb.size());
        end
        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
